dmem_bytelane: RTL and testbench
================================

# dmem_bytelane

Parametrised, byte-addressable data memory for the RISC-V core's MEM stage, succeeding the single-word combinational-read data memory. It adds byte, halfword, word and doubleword accesses with byte-lane writes and sign/zero-extended loads. Reads are registered behind a valid/ready request port with a one-cycle response. After reset, a clear sequencer zeroes the array one word per cycle, so the memory maps to block RAM instead of a flop array with a parallel reset.

## Interface
- DATA_WIDTH, 32: word width; 32 or 64 only.
- DEPTH, 256: number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH)+$clog2(DATA_WIDTH/8): byte address width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (low bytes used).
- rsp_valid  out  1  response for the request accepted on the previous edge.
- rsp_rdata  out  DATA_WIDTH  load result, extended to DATA_WIDTH; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned, illegal size, out of range).
- init_done  out  1  clear sequence complete.

## Operation
- States: CLEAR and READY.
- Reset values: state CLEAR, clear counter 0, req_ready 0, init_done 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- CLEAR:
  - Each edge writes word[counter] = 0 and increments the counter.
  - When counter == DEPTH-1 is written, go to READY.
  - req_ready = 0.
- READY:
  - req_ready = 1 and init_done = 1 continuously. One request can be accepted per cycle.
- Word index = req_addr >> $clog2(DATA_WIDTH/8). Byte offset = the low address bits.
- Error conditions; any one sets rsp_err = 1:
  - size 3 with DATA_WIDTH = 32;
  - word index >= DEPTH;
  - misaligned access: offset not a multiple of 2^size.
- An errored request performs no write and returns rsp_rdata = 0.
- Store:
  - Byte lanes offset .. offset+2^size-1 are written with req_wdata[8*2^size-1:0] at the accepting edge.
  - Other lanes are unchanged.
- Load:
  - The selected bytes are shifted down to bit 0.
  - Extension: sign-extended from the top selected bit, or zero-extended when req_unsigned = 1.
  - Size equal to the full width ignores req_unsigned.
- A rst assertion in any state forces the reset values on the next edge:
  - the in-flight response is dropped;
  - the clear restarts from word 0.

## Timing
- Load/store latency: 1 cycle. rsp_valid is high in the cycle after acceptance, for exactly one cycle per accepted request.
- Back-to-back requests are allowed every cycle. rsp_valid stays high while requests are accepted each cycle.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. No same-cycle conflict exists (single port).
- Clear duration: DEPTH edges after rst deasserts. init_done and req_ready rise after edge DEPTH.
- No backpressure on the response; the consumer must take rsp_* in the valid cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN:
  - Defined: misaligned accesses set rsp_err as above, with no write and rdata 0.
  - Undefined: the offset low bits are forced to alignment (offset & ~(2^size-1)), the access proceeds normally, and rsp_err is asserted only for illegal size or out-of-range index.

## Test plan
- Reset and clear: with DEPTH = 256, pulse rst for 1 cycle -> req_ready = 0 for 256 cycles, then init_done = 1; a load of word at address 0x3FC returns 0.
- Byte store/load: SW 0x80FF7F01 @0x10, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80FF; LB @0x10 -> 0x00000001.
- Lane isolation: SW 0x11223344 @0x20, SB 0xAA @0x21, then LW @0x20 -> 0x1122AA44. Back-to-back issue gives rsp_valid on 3 consecutive cycles.
- Errors, macro defined: LH @0x21 -> rsp_err = 1, rdata 0, memory unchanged. LW @(DEPTH*4) -> rsp_err = 1. Size 3 at DATA_WIDTH = 32 -> rsp_err = 1.
- Macro undefined: SW 0xDEADBEEF @0x32 writes word 0x30. LW @0x30 -> 0xDEADBEEF with rsp_err = 0.
- Mid-operation reset: assert rst the cycle a load is accepted -> rsp_valid = 0 on the next cycle, the clear restarts, and previously stored data reads 0 after init_done.
- DATA_WIDTH = 64, DEPTH = 100: SD 0x0123456789ABCDEF @0x8, then LW @0xC -> 0x0000000001234567; an access at address 800 -> rsp_err = 1.

Source files
------------

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle for dmem_bytelane.
// master: the MEM-stage requester; slave: the memory itself.
interface dmem_bytelane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory with byte/half/word/dword accesses,
// byte-lane stores, sign/zero-extended loads and a one-cycle registered
// response. After reset a clear sequencer zeroes one word per cycle so the
// array carries no reset and can map onto block RAM.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned accesses are rejected with rsp_err
//   undefined - the byte offset is rounded down to the access alignment
module dmem_bytelane #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + $clog2(DATA_WIDTH / 8)
) (
  input logic            clk,
  input logic            rst,
  dmem_bytelane_if.slave bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;

  localparam logic [IDX_W:0]   DEPTH_V  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      cnt;
  logic                  ready_q;
  logic                  done_q;
  logic                  valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Request decode signals
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      safe_idx;
  logic [OFF_W-1:0]      off;
  logic [OFF_W-1:0]      align_mask;
  logic [OFF_W-1:0]      off_eff;
  logic                  size_err;
  logic                  range_err;
  logic                  req_err;
  logic [NB-1:0]         size_lanes;
  logic [NB-1:0]         lane_mask;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] word_sh;
  logic [DATA_WIDTH-1:0] low_mask;
  logic [DATA_WIDTH-1:0] ones;
  logic                  sign;
  logic [DATA_WIDTH-1:0] load_val;
  int unsigned           nbits;
  logic                  accept;

  assign accept        = bus.req_valid && ready_q;

  assign bus.req_ready = ready_q;
  assign bus.init_done = done_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

  // Decode address, check legality, and form store lanes and load data
  always_comb begin
    idx        = bus.req_addr[ADDR_WIDTH-1:OFF_W];
    off        = bus.req_addr[OFF_W-1:0];
    align_mask = OFF_W'((32'd1 << bus.req_size) - 32'd1);
    size_err   = (DATA_WIDTH == 32) && (bus.req_size == 2'd3);
    range_err  = ({1'b0, idx} >= DEPTH_V);
`ifdef DMEM_MISALIGN_TRAP_EN
    req_err    = size_err || range_err || ((off & align_mask) != '0);
    off_eff    = off;
`else
    req_err    = size_err || range_err;
    off_eff    = off & ~align_mask;
`endif
    safe_idx   = range_err ? '0 : idx;

    // Store: place the low 2^size bytes of wdata at the selected lanes
    size_lanes = NB'((32'd1 << (32'd1 << bus.req_size)) - 32'd1);
    lane_mask  = size_lanes << off_eff;
    wdata_sh   = bus.req_wdata << {off_eff, 3'b000};

    // Load: shift selected bytes to bit 0; the mask's top set bit is the
    // sign position, and a full-width access leaves no bits to extend
    nbits      = 32'd8 << bus.req_size;
    ones       = '1;
    low_mask   = ~(ones << nbits);
    word_sh    = mem[safe_idx] >> {off_eff, 3'b000};
    sign       = |(word_sh & low_mask & ~(low_mask >> 1));
    load_val   = word_sh & low_mask;
    if (!bus.req_unsigned && sign) begin
      load_val = load_val | ~low_mask;
    end
  end

  // Control FSM: clear sequence, then one registered response per request
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          valid_q <= 1'b0;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state   <= READY;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        READY: begin
          valid_q <= accept;
          if (accept) begin
            err_q   <= req_err;
            rdata_q <= (req_err || bus.req_we) ? '0 : load_val;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Array write port: clear sweep, or byte-lane store of a legal request
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (accept && bus.req_we && !req_err) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (lane_mask[b]) begin
            mem[safe_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: a 32-bit/256-word instance driven
// by directed and random requests against a byte-array reference model, and
// a 64-bit/100-word instance checked with directed dword cases.
module tb_dmem_bytelane;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b32 ();
  dmem_bytelane_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) b64 ();

  dmem_bytelane #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(10)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  dmem_bytelane #(.DATA_WIDTH(64), .DEPTH(100), .ADDR_WIDTH(10)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] exp_rd[$];
  logic        exp_er[$];
  logic [31:0] obs_rd[$];
  logic        obs_er[$];
  logic        obs_v[$];
  logic        tail_v;

  // Reference: 1024 bytes, little-endian words of 4 bytes
  logic [7:0]  ref_mem [1024];

  function automatic void ref_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic void model(input req_t r, output logic [31:0] rd, output logic er);
    int nb;
    int idx;
    int off;
    logic [63:0] v;
    nb  = 1 << r.size;
    idx = int'(r.addr) / 4;
    off = int'(r.addr) % 4;
    er  = (r.size == 2'd3) || (idx >= 256);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (off % nb != 0) er = 1'b1;
`else
    off = off - (off % nb);
`endif
    rd = 32'h0;
    if (er) return;
    if (r.we) begin
      for (int i = 0; i < nb; i++) ref_mem[idx*4 + off + i] = r.wdata[8*i +: 8];
    end else begin
      v = 64'h0;
      for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[idx*4 + off + i]) << (8*i));
      if (!r.uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                              input logic [9:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endfunction

  // Issue all queued requests back to back on the 32-bit port, recording
  // model expectations and the observed response of each cycle
  task automatic run32();
    int          n;
    req_t        r;
    logic [31:0] rd;
    logic        er;
    n = req_q.size();
    exp_rd.delete(); exp_er.delete();
    obs_rd.delete(); obs_er.delete(); obs_v.delete();
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k > 0) begin
        obs_v.push_back(b32.rsp_valid);
        obs_rd.push_back(b32.rsp_rdata);
        obs_er.push_back(b32.rsp_err);
      end
      if (k < n) begin
        r = req_q[k];
        b32.req_valid    = 1'b1;
        b32.req_we       = r.we;
        b32.req_size     = r.size;
        b32.req_unsigned = r.uns;
        b32.req_addr     = r.addr;
        b32.req_wdata    = r.wdata;
        model(r, rd, er);
        exp_rd.push_back(rd);
        exp_er.push_back(er);
      end else begin
        b32.req_valid = 1'b0;
      end
    end
    @(negedge clk);
    tail_v = b32.rsp_valid;
    req_q.delete();
  endtask

  task automatic req64(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rd, output logic er, output logic v);
    @(negedge clk);
    b64.req_valid    = 1'b1;
    b64.req_we       = we;
    b64.req_size     = size;
    b64.req_unsigned = uns;
    b64.req_addr     = addr;
    b64.req_wdata    = wdata;
    @(negedge clk);
    b64.req_valid = 1'b0;
    rd = b64.rsp_rdata;
    er = b64.rsp_err;
    v  = b64.rsp_valid;
  endtask

  task automatic test_reset();
    int   cyc;
    logic init_bad;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (b32.req_ready !== 1'b0 || b32.init_done !== 1'b0 || b32.rsp_valid !== 1'b0 ||
        b32.rsp_err !== 1'b0 || b32.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b done=%b valid=%b err=%b rdata=%h, want all 0",
               b32.req_ready, b32.init_done, b32.rsp_valid, b32.rsp_err, b32.rsp_rdata);
    end
    rst = 1'b0;
    cyc = 0;
    init_bad = 1'b0;
    while (b32.req_ready !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (b32.init_done !== b32.req_ready) init_bad = 1'b1;
    end
    checks++;
    if (cyc != 256) begin
      errors++;
      $display("FAIL clear_length: ready after %0d cycles, want 256", cyc);
    end
    checks++;
    if (init_bad || b32.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done: done=%b tracking_bad=%b, want 1 rising with req_ready",
               b32.init_done, init_bad);
    end
    ref_clear();
    add(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);
    run32();
    checks++;
    if (obs_v[0] !== 1'b1 || obs_rd[0] !== 32'h0 || obs_er[0] !== 1'b0) begin
      errors++;
      $display("FAIL cleared_load: valid=%b rdata=%h err=%b, want 1 00000000 0",
               obs_v[0], obs_rd[0], obs_er[0]);
    end
  endtask

  task automatic test_byte_access();
    logic [31:0] want [5];
    want[0] = 32'h0; want[1] = 32'hFFFFFF80; want[2] = 32'h00000080;
    want[3] = 32'hFFFF80FF; want[4] = 32'h00000001;
    add(1'b1, 2'd2, 1'b0, 10'h010, 32'h80FF7F01);
    add(1'b0, 2'd0, 1'b0, 10'h013, 32'h0);
    add(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    add(1'b0, 2'd1, 1'b0, 10'h012, 32'h0);
    add(1'b0, 2'd0, 1'b0, 10'h010, 32'h0);
    run32();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_v[i] !== 1'b1 || obs_rd[i] !== want[i] || obs_er[i] !== 1'b0) begin
        errors++;
        $display("FAIL byte_access[%0d]: valid=%b rdata=%h err=%b, want 1 %h 0",
                 i, obs_v[i], obs_rd[i], obs_er[i], want[i]);
      end
    end
  endtask

  task automatic test_lane_isolation();
    add(1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344);
    add(1'b1, 2'd0, 1'b0, 10'h021, 32'h000000AA);
    add(1'b0, 2'd2, 1'b0, 10'h020, 32'h0);
    run32();
    checks++;
    if (obs_v[0] !== 1'b1 || obs_v[1] !== 1'b1 || obs_v[2] !== 1'b1 || tail_v !== 1'b0) begin
      errors++;
      $display("FAIL lane_valid_train: valid=%b%b%b tail=%b, want 1110",
               obs_v[0], obs_v[1], obs_v[2], tail_v);
    end
    checks++;
    if (obs_rd[2] !== 32'h1122AA44 || obs_er[2] !== 1'b0) begin
      errors++;
      $display("FAIL lane_isolation: rdata=%h err=%b, want 1122aa44 0", obs_rd[2], obs_er[2]);
    end
  endtask

  task automatic test_errors();
`ifdef DMEM_MISALIGN_TRAP_EN
    add(1'b0, 2'd1, 1'b0, 10'h021, 32'h0);
    add(1'b1, 2'd1, 1'b0, 10'h021, 32'h0000BEEF);
    add(1'b0, 2'd2, 1'b0, 10'h020, 32'h0);
    add(1'b0, 2'd3, 1'b0, 10'h020, 32'h0);
    run32();
    checks++;
    if (obs_er[0] !== 1'b1 || obs_rd[0] !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_load: err=%b rdata=%h, want 1 00000000", obs_er[0], obs_rd[0]);
    end
    checks++;
    if (obs_er[1] !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store: err=%b, want 1", obs_er[1]);
    end
    checks++;
    if (obs_rd[2] !== 32'h1122AA44 || obs_er[2] !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_write: rdata=%h err=%b, want 1122aa44 0", obs_rd[2], obs_er[2]);
    end
`else
    add(1'b1, 2'd2, 1'b0, 10'h032, 32'hDEADBEEF);
    add(1'b0, 2'd2, 1'b0, 10'h030, 32'h0);
    add(1'b0, 2'd3, 1'b0, 10'h020, 32'h0);
    run32();
    checks++;
    if (obs_er[0] !== 1'b0) begin
      errors++;
      $display("FAIL aligned_store_err: err=%b, want 0", obs_er[0]);
    end
    checks++;
    if (obs_rd[1] !== 32'hDEADBEEF || obs_er[1] !== 1'b0) begin
      errors++;
      $display("FAIL forced_align: rdata=%h err=%b, want deadbeef 0", obs_rd[1], obs_er[1]);
    end
`endif
    checks++;
    if (obs_er[obs_er.size()-1] !== 1'b1 || obs_rd[obs_rd.size()-1] !== 32'h0) begin
      errors++;
      $display("FAIL size3_on_32: err=%b rdata=%h, want 1 00000000",
               obs_er[obs_er.size()-1], obs_rd[obs_rd.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    logic [1:0] sz;
    for (int i = 0; i < 80; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      add(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63)),
          $urandom());
    end
    run32();
    n = obs_v.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_v[i] !== 1'b1 || obs_rd[i] !== exp_rd[i] || obs_er[i] !== exp_er[i]) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL random[%0d]: valid=%b rdata=%h err=%b, want 1 %h %b",
                   i, obs_v[i], obs_rd[i], obs_er[i], exp_rd[i], exp_er[i]);
      end
    end
    checks++;
    if (tail_v !== 1'b0) begin
      errors++;
      $display("FAIL random_tail_valid: valid=%b, want 0", tail_v);
    end
  endtask

  task automatic test_dword_64();
    logic [63:0] rd;
    logic        er;
    logic        v;
    int          cyc;
    cyc = 0;
    while (b64.init_done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (b64.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init64: init_done=%b, want 1", b64.init_done);
    end
    req64(1'b1, 2'd3, 1'b0, 10'd8, 64'h0123456789ABCDEF, rd, er, v);
    checks++;
    if (v !== 1'b1 || er !== 1'b0 || rd !== 64'h0) begin
      errors++;
      $display("FAIL sd64: valid=%b err=%b rdata=%h, want 1 0 0", v, er, rd);
    end
    req64(1'b0, 2'd2, 1'b0, 10'h00C, 64'h0, rd, er, v);
    checks++;
    if (v !== 1'b1 || er !== 1'b0 || rd !== 64'h0000000001234567) begin
      errors++;
      $display("FAIL lw64: valid=%b err=%b rdata=%h, want 1 0 0000000001234567", v, er, rd);
    end
    req64(1'b0, 2'd3, 1'b1, 10'd8, 64'h0, rd, er, v);
    checks++;
    if (er !== 1'b0 || rd !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL ld64: err=%b rdata=%h, want 0 0123456789abcdef", er, rd);
    end
    req64(1'b0, 2'd0, 1'b0, 10'h00B, 64'h0, rd, er, v);
    checks++;
    if (er !== 1'b0 || rd !== 64'hFFFFFFFFFFFFFF89) begin
      errors++;
      $display("FAIL lb64: err=%b rdata=%h, want 0 ffffffffffffff89", er, rd);
    end
    req64(1'b0, 2'd2, 1'b0, 10'd800, 64'h0, rd, er, v);
    checks++;
    if (v !== 1'b1 || er !== 1'b1 || rd !== 64'h0) begin
      errors++;
      $display("FAIL range64: valid=%b err=%b rdata=%h, want 1 1 0", v, er, rd);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    add(1'b1, 2'd2, 1'b0, 10'h040, 32'h5A5A5A5A);
    run32();
    @(negedge clk);
    b32.req_valid    = 1'b1;
    b32.req_we       = 1'b0;
    b32.req_size     = 2'd2;
    b32.req_unsigned = 1'b0;
    b32.req_addr     = 10'h040;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b32.req_valid = 1'b0;
    checks++;
    if (b32.rsp_valid !== 1'b0 || b32.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_rsp: valid=%b ready=%b, want 0 0", b32.rsp_valid, b32.req_ready);
    end
    cyc = 0;
    while (b32.req_ready !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 256) begin
      errors++;
      $display("FAIL reclear_length: ready after %0d cycles, want 256", cyc);
    end
    ref_clear();
    add(1'b0, 2'd2, 1'b0, 10'h040, 32'h0);
    run32();
    checks++;
    if (obs_v[0] !== 1'b1 || obs_rd[0] !== 32'h0 || obs_er[0] !== 1'b0) begin
      errors++;
      $display("FAIL reclear_data: valid=%b rdata=%h err=%b, want 1 00000000 0",
               obs_v[0], obs_rd[0], obs_er[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_size = 2'd0;
    b32.req_unsigned = 1'b0; b32.req_addr = '0; b32.req_wdata = '0;
    b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_size = 2'd0;
    b64.req_unsigned = 1'b0; b64.req_addr = '0; b64.req_wdata = '0;
    test_reset();
    test_byte_access();
    test_lane_isolation();
    test_errors();
    test_back_to_back();
    test_dword_64();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
